program_loader: RTL

//  Boot/load sequencer for the multi-cycle MIPS core. Holds the core in reset, accepts a

---
 rtl/program_loader_pkg.sv | 12 +
 rtl/program_loader_byte_packer.sv | 32 +++
 rtl/program_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the boot/load sequencer.
package program_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam int BYTE_LANES = 4;
endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);
  logic [1:0]  r_lane;
  logic [31:0] r_word;

  // The lane counter wraps to 0 on the fourth byte, ready for the next word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (i_valid) begin
      r_word[8*r_lane +: 8] <= i_byte;
      r_lane                <= r_lane + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_valid && (r_lane == 2'(BYTE_LANES - 1));
endmodule

// File: rtl/program_loader.sv
// Boot loader: holds the MIPS core in reset, streams a program into memory, then hands over the port.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          LEN_W          = 16,
  parameter int          RELEASE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_length,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [31:0]      cpu_address,
  input  logic [31:0]      cpu_data_out,
  input  logic             cpu_mem_write,
  output logic             cpu_reset,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_out,
  output logic             mem_write,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_loaded,
  output state_t           dbg_state
);
  // rx handshake: a byte moves on any rising edge where rx_valid && rx_ready.
  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

  state_t           r_state, w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words_loaded;
  logic [LEN_W-1:0] w_words_inc;
  logic [CNT_W-1:0] r_rel_cnt;
  logic             r_done;
  logic             w_start;
  logic             w_xfer;
  logic             w_word_ready;
  logic [31:0]      w_word;

  assign w_start     = load_start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_xfer      = rx_valid && rx_ready;
  assign w_words_inc = r_words_loaded + 1'b1;

  program_loader_byte_packer u_packer (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_clear      (w_start),
    .i_valid      (w_xfer),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: if (w_start) w_next_state = (load_length == '0) ? ST_RELEASE : ST_COLLECT;
      ST_COLLECT:      if (w_word_ready) w_next_state = ST_WRITE;
      ST_WRITE:        w_next_state = (w_words_inc == r_len) ? ST_RELEASE : ST_COLLECT;
      ST_RELEASE:      if (r_rel_cnt <= CNT_W'(1)) w_next_state = ST_RUN;
      default:         w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len          <= '0;
      r_words_loaded <= '0;
      r_rel_cnt      <= '0;
      r_done         <= 1'b0;
    end else begin
      if (w_start) begin
        r_len          <= load_length;
        r_words_loaded <= '0;
      end else if (r_state == ST_WRITE) begin
        r_words_loaded <= w_words_inc;
      end
      // Counter is loaded on entry so RELEASE lasts exactly RELEASE_CYCLES cycles.
      if ((w_next_state == ST_RELEASE) && (r_state != ST_RELEASE))
        r_rel_cnt <= CNT_W'(RELEASE_CYCLES);
      else if (r_state == ST_RELEASE)
        r_rel_cnt <= r_rel_cnt - 1'b1;
      r_done <= (r_state == ST_RELEASE) && (w_next_state == ST_RUN);
    end
  end

  assign rx_ready     = (r_state == ST_COLLECT);
  assign cpu_reset    = (r_state != ST_RUN);
  assign busy         = (r_state == ST_COLLECT) || (r_state == ST_WRITE) || (r_state == ST_RELEASE);
  assign done         = r_done;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

  // In RUN the core owns the memory port with no added latency.
  assign mem_address  = (r_state == ST_RUN) ? cpu_address
                                            : BASE_ADDR + (32'(r_words_loaded) << 2);
  assign mem_data_out = (r_state == ST_RUN) ? cpu_data_out : w_word;
  assign mem_write    = (r_state == ST_RUN) ? cpu_mem_write : (r_state == ST_WRITE);
endmodule
